rv_main_control_fsm: RTL and testbench
======================================

// Module: rv_main_control_fsm
// PURPOSE
//  Multicycle main control FSM for the RV32I core. Decodes IR opcode/funct3 and sequences datapath strobes.
//  Drives ALUOp[1:0] into the ALU control decoder (00 add, 01 sub, 10 decode funct3/funct7 by OP).
//  Resolves branches from ALU flags. Handshakes with unified instr/data memory via mem_ready.
// PARAMETERS
//  USE_MEM_READY  1  1: FETCH/MEMRD/MEMWR stall until mem_ready; 0: mem_ready ignored (treated as 1)
// PORTS
//  clk            in   1  core clock, rising edge
//  rst_n          in   1  asynchronous, active-low reset
//  OP             in   7  IR[6:0]
//  funct3         in   3  IR[14:12]
//  Zero, LT, LTU  in   1  ALU flags for A-B: equal, signed less-than, unsigned less-than
//  mem_ready      in   1  memory access completes this cycle
//  PCWrite        out  1  load PC this edge
//  IorD           out  1  mem addr: 0 PC, 1 ALUOut
//  MemRead        out  1  memory read request
//  MemWrite       out  1  memory write request
//  IRWrite        out  1  load IR and OldPC
//  RegWrite       out  1  register file write
//  MemtoReg       out  2  wb data: 00 ALUOut, 01 MDR, 10 PC (=OldPC+4)
//  ALUSrcA        out  2  00 PC, 01 OldPC, 10 A reg, 11 zero
//  ALUSrcB        out  2  00 B reg, 01 const 4, 10 imm, 11 reserved (never driven)
//  ALUOp          out  2  to ALU control
//  PCSource       out  2  00 ALU result, 01 ALUOut, 1x reserved
//  instr_retired  out  1  1-cycle pulse in final cycle of each instruction
//  illegal_instr  out  1  sticky illegal-opcode flag (ILLEGAL_TRAP_EN only; else tied 0)
//  state          out  4  current state encoding (debug)
// BEHAVIOUR
//  Moore outputs from state reg; PCWrite/IRWrite/instr_retired also depend on mem_ready/flags.
//  Unlisted outputs are 0 in every state. rst_n low -> state=RST(0), all outputs 0.
//  RST(0): all strobes 0 -> FETCH. Async assert mid-instruction aborts it at once; no partial write.
//  FETCH(1): MemRead, IorD=0, SrcA=00, SrcB=01, ALUOp=00, PCSource=00.
//    IRWrite=PCWrite=mem_ready. Hold while !mem_ready; else -> DECODE.
//  DECODE(2): SrcA=01, SrcB=10, ALUOp=00 (ALUOut<=OldPC+imm). Next by OP:
//    0000011/0100011 MEMADR; 0110011 EXEC_R; 0010011 EXEC_I; 1100011 BRANCH; 1101111 JAL;
//    1100111 JALR; 0110111 LUI; 0010111 AUIPC; 0001111/1110011 NOP: pulse retired -> FETCH; other ILLEGAL.
//  MEMADR(3): SrcA=10, SrcB=10, ALUOp=00 -> MEMRD if OP[5]=0 else MEMWR.
//  MEMRD(4): MemRead, IorD=1; hold until mem_ready -> MEMWB.
//  MEMWB(5): RegWrite, MemtoReg=01, retired -> FETCH.
//  MEMWR(6): MemWrite, IorD=1; hold until mem_ready; retired when mem_ready -> FETCH.
//  EXEC_R(7): SrcA=10, SrcB=00, ALUOp=10 -> ALUWB.   EXEC_I(8): SrcA=10, SrcB=10, ALUOp=10 -> ALUWB.
//  ALUWB(9): RegWrite, MemtoReg=00, retired -> FETCH.
//  BRANCH(10): SrcA=10, SrcB=00, ALUOp=01, PCSource=01, PCWrite=taken, retired -> FETCH.
//    taken by funct3: 000 Zero, 001 !Zero, 100 LT, 101 !LT, 110 LTU, 111 !LTU, 010/011 0.
//  JAL(11): PCWrite, PCSource=01, RegWrite, MemtoReg=10, retired -> FETCH.
//  JALR(12): SrcA=10, SrcB=10, ALUOp=00, PCSource=00, PCWrite, RegWrite, MemtoReg=10, retired -> FETCH.
//    rd gets pre-update PC (=OldPC+4); rd==rs1 safe, A reg latched earlier.
//  LUI(13): SrcA=11, SrcB=10, ALUOp=00 -> ALUWB.   AUIPC(14): SrcA=01, SrcB=10, ALUOp=00 -> ALUWB.
//  ILLEGAL(15): see CONFIGURATION. Cycles at mem_ready=1: ALU/LUI/AUIPC/store 4, load 5, branch/jal/jalr 3.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: ILLEGAL sets illegal_instr, all strobes 0, holds until rst_n; no retired pulse.
//  ILLEGAL_TRAP_EN undefined: ILLEGAL = NOP: retired pulse -> FETCH; illegal_instr tied 0.
// TESTING
//  Reset release, mem_ready=1: RST 1 cycle, FETCH: MemRead=1, IRWrite=1, PCWrite=1, SrcB=01.
//  add (OP=0110011): states 1,2,7,9; EXEC_R ALUOp=10 SrcB=00; ALUWB RegWrite=1; retired 4th cycle.
//  lw, mem_ready low 2 cycles in MEMRD: MEMRD held 3 cycles, MemRead/IorD=1 throughout; MEMWB RegWrite, MemtoReg=01.
//  beq Zero=1 -> PCWrite=1, PCSource=01; bne Zero=1 -> PCWrite=0; bltu LTU=1 -> PCWrite=1; funct3=010 -> 0.
//  jal: 3 cycles; JAL PCWrite=RegWrite=1, MemtoReg=10. rst_n low in MEMWR: all outputs 0 at once, state=0.
//  OP=1111111: trap build -> illegal_instr=1, state 15 held 10+ cycles; non-trap -> retired, back to FETCH.

Source files
------------

// File: rtl/rv_main_control_fsm.sv
// rv_main_control_fsm
// Multicycle main control FSM for an RV32I core with a unified instruction/data
// memory. Decodes the IR opcode, sequences datapath strobes one state per cycle,
// resolves conditional branches from the ALU flags of A-B and stalls memory
// states on mem_ready.
// Build option: define ILLEGAL_TRAP_EN to trap on unknown opcodes. The sticky
// illegal_instr flag is raised and the FSM parks in ILLEGAL until reset. Without
// the macro, unknown opcodes retire as NOPs and illegal_instr is tied low.
module rv_main_control_fsm #(
  parameter int unsigned USE_MEM_READY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] OP,
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       LT,
  input  logic       LTU,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_retired,
  output logic       illegal_instr,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC_R  = 4'd7,
    S_EXEC_I  = 4'd8,
    S_ALUWB   = 4'd9,
    S_BRANCH  = 4'd10,
    S_JAL     = 4'd11,
    S_JALR    = 4'd12,
    S_LUI     = 4'd13,
    S_AUIPC   = 4'd14,
    S_ILLEGAL = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t r_state;
  state_t w_state_next;
  logic   w_mem_ready;
  logic   w_taken;

  // With the handshake disabled every memory access completes in one cycle.
  assign w_mem_ready = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
  assign state       = r_state;

  // Branch condition: select the flag of A-B that matches funct3.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves w_taken unassigned
    // (a missed path would infer a latch).
    w_taken = 1'b0;
    case (funct3)
      3'b000:  w_taken = Zero;
      3'b001:  w_taken = !Zero;
      3'b100:  w_taken = LT;
      3'b101:  w_taken = !LT;
      3'b110:  w_taken = LTU;
      3'b111:  w_taken = !LTU;
      default: w_taken = 1'b0;
    endcase
  end

  // State register. An async reset aborts the instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values.
    if (!rst_n) r_state <= S_RST;
    else        r_state <= w_state_next;
  end

  // Next-state decode and strobes. Outputs depend on the state; PCWrite, IRWrite
  // and instr_retired also depend on mem_ready and the branch flags.
  always_comb begin
    w_state_next  = r_state;
    PCWrite       = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    MemtoReg      = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    PCSource      = 2'b00;
    instr_retired = 1'b0;

    case (r_state)
      S_RST: w_state_next = S_FETCH;

      // Read the instruction at PC and compute PC+4 in the same cycle.
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = w_mem_ready;
        PCWrite = w_mem_ready;
        if (w_mem_ready) w_state_next = S_DECODE;
      end

      // Speculative branch/jump target: ALUOut <= OldPC + imm.
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        case (OP)
          OP_LOAD, OP_STORE: w_state_next = S_MEMADR;
          OP_REG:            w_state_next = S_EXEC_R;
          OP_IMM:            w_state_next = S_EXEC_I;
          OP_BRANCH:         w_state_next = S_BRANCH;
          OP_JAL:            w_state_next = S_JAL;
          OP_JALR:           w_state_next = S_JALR;
          OP_LUI:            w_state_next = S_LUI;
          OP_AUIPC:          w_state_next = S_AUIPC;
          OP_FENCE, OP_SYSTEM: begin
            instr_retired = 1'b1;
            w_state_next  = S_FETCH;
          end
          default:           w_state_next = S_ILLEGAL;
        endcase
      end

      // Effective address; OP[5] distinguishes a store from a load.
      S_MEMADR: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b10;
        w_state_next = OP[5] ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (w_mem_ready) w_state_next = S_MEMWB;
      end

      S_MEMWB: begin
        RegWrite      = 1'b1;
        MemtoReg      = 2'b01;
        instr_retired = 1'b1;
        w_state_next  = S_FETCH;
      end

      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (w_mem_ready) begin
          instr_retired = 1'b1;
          w_state_next  = S_FETCH;
        end
      end

      S_EXEC_R: begin
        ALUSrcA      = 2'b10;
        ALUOp        = 2'b10;
        w_state_next = S_ALUWB;
      end

      S_EXEC_I: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b10;
        ALUOp        = 2'b10;
        w_state_next = S_ALUWB;
      end

      S_ALUWB: begin
        RegWrite      = 1'b1;
        instr_retired = 1'b1;
        w_state_next  = S_FETCH;
      end

      // Compare A-B; the target computed in DECODE sits in ALUOut.
      S_BRANCH: begin
        ALUSrcA       = 2'b10;
        ALUOp         = 2'b01;
        PCSource      = 2'b01;
        PCWrite       = w_taken;
        instr_retired = 1'b1;
        w_state_next  = S_FETCH;
      end

      S_JAL: begin
        PCWrite       = 1'b1;
        PCSource      = 2'b01;
        RegWrite      = 1'b1;
        MemtoReg      = 2'b10;
        instr_retired = 1'b1;
        w_state_next  = S_FETCH;
      end

      // rd takes the pre-update PC; A was latched earlier, so rd==rs1 is safe.
      S_JALR: begin
        ALUSrcA       = 2'b10;
        ALUSrcB       = 2'b10;
        PCWrite       = 1'b1;
        RegWrite      = 1'b1;
        MemtoReg      = 2'b10;
        instr_retired = 1'b1;
        w_state_next  = S_FETCH;
      end

      S_LUI: begin
        ALUSrcA      = 2'b11;
        ALUSrcB      = 2'b10;
        w_state_next = S_ALUWB;
      end

      S_AUIPC: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        w_state_next = S_ALUWB;
      end

      S_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
        w_state_next = S_ILLEGAL;
`else
        instr_retired = 1'b1;
        w_state_next  = S_FETCH;
`endif
      end

      default: w_state_next = S_RST;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;

  // Sticky trap flag: set on entry to ILLEGAL and cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_illegal <= 1'b0;
    else if (w_state_next == S_ILLEGAL) r_illegal <= 1'b1;
  end

  assign illegal_instr = r_illegal;
`else
  assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_rv_main_control_fsm.sv
// tb_rv_main_control_fsm
// Directed and randomized instructions for rv_main_control_fsm. A reference
// model expands each instruction into its list of phases, steps through that
// list against mem_ready, and derives the expected strobes for each cycle.
module tb_rv_main_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] OP;
  logic [2:0] funct3;
  logic       Zero, LT, LTU, mem_ready;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource;
  logic       instr_retired, illegal_instr;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv_main_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .OP(OP), .funct3(funct3),
    .Zero(Zero), .LT(LT), .LTU(LTU), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .instr_retired(instr_retired), .illegal_instr(illegal_instr), .state(state)
  );

  typedef struct packed {
    logic [1:0] srca, srcb, aluop, pcsrc, mtoreg;
    logic       iord, memrd, memwr, regwr;
  } ctl_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Datapath controls defined for each numbered phase.
  function automatic ctl_t ctl_of(input int st);
    ctl_t c;
    c = '0;
    case (st)
      1:  begin c.memrd = 1'b1; c.srcb = 2'b01; end
      2:  begin c.srca = 2'b01; c.srcb = 2'b10; end
      3:  begin c.srca = 2'b10; c.srcb = 2'b10; end
      4:  begin c.memrd = 1'b1; c.iord = 1'b1; end
      5:  begin c.regwr = 1'b1; c.mtoreg = 2'b01; end
      6:  begin c.memwr = 1'b1; c.iord = 1'b1; end
      7:  begin c.srca = 2'b10; c.aluop = 2'b10; end
      8:  begin c.srca = 2'b10; c.srcb = 2'b10; c.aluop = 2'b10; end
      9:  begin c.regwr = 1'b1; end
      10: begin c.srca = 2'b10; c.aluop = 2'b01; c.pcsrc = 2'b01; end
      11: begin c.pcsrc = 2'b01; c.regwr = 1'b1; c.mtoreg = 2'b10; end
      12: begin c.srca = 2'b10; c.srcb = 2'b10; c.regwr = 1'b1; c.mtoreg = 2'b10; end
      13: begin c.srca = 2'b11; c.srcb = 2'b10; end
      14: begin c.srca = 2'b01; c.srcb = 2'b10; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [17:0] all_outs();
    return {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, MemtoReg,
            ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_retired, illegal_instr};
  endfunction

  // Runs one instruction from FETCH to retirement. A and B are the operands, and
  // the ALU flags are derived from them. mr_mask bit i is mem_ready in cycle i.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] mr_mask);
    int   seq[$];
    int   idx, cyc, st;
    logic taken, mr, adv, last, exp_pcw;
    ctl_t c;
    OP = op; funct3 = f3;
    Zero = (a == b); LT = ($signed(a) < $signed(b)); LTU = (a < b);
    case (f3)
      3'd0:    taken = (a == b);
      3'd1:    taken = (a != b);
      3'd4:    taken = ($signed(a) < $signed(b));
      3'd5:    taken = ($signed(a) >= $signed(b));
      3'd6:    taken = (a < b);
      3'd7:    taken = (a >= b);
      default: taken = 1'b0;
    endcase
    seq = {1, 2};
    case (op)
      7'b0000011: begin seq.push_back(3); seq.push_back(4); seq.push_back(5); end
      7'b0100011: begin seq.push_back(3); seq.push_back(6); end
      7'b0110011: begin seq.push_back(7); seq.push_back(9); end
      7'b0010011: begin seq.push_back(8); seq.push_back(9); end
      7'b0110111: begin seq.push_back(13); seq.push_back(9); end
      7'b0010111: begin seq.push_back(14); seq.push_back(9); end
      7'b1100011: seq.push_back(10);
      7'b1101111: seq.push_back(11);
      7'b1100111: seq.push_back(12);
      7'b0001111, 7'b1110011: ;
      default:    seq.push_back(15);
    endcase
    idx = 0;
    cyc = 0;
    while (idx < seq.size() && cyc < 64) begin
      mr = (cyc < 32) ? mr_mask[cyc] : 1'b1;
      mem_ready = mr;
      #1;
      st   = seq[idx];
      adv  = !(st == 1 || st == 4 || st == 6) || mr;
      last = (idx == seq.size() - 1);
      c    = ctl_of(st);
      exp_pcw = (st == 1 && mr) || (st == 10 && taken) || st == 11 || st == 12;
      check({name, ":state"},    state,         st);
      check({name, ":MemRead"},  MemRead,       c.memrd);
      check({name, ":MemWrite"}, MemWrite,      c.memwr);
      check({name, ":IorD"},     IorD,          c.iord);
      check({name, ":RegWrite"}, RegWrite,      c.regwr);
      check({name, ":MemtoReg"}, MemtoReg,      c.mtoreg);
      check({name, ":ALUSrcA"},  ALUSrcA,       c.srca);
      check({name, ":ALUSrcB"},  ALUSrcB,       c.srcb);
      check({name, ":ALUOp"},    ALUOp,         c.aluop);
      check({name, ":PCSource"}, PCSource,      c.pcsrc);
      check({name, ":PCWrite"},  PCWrite,       exp_pcw);
      check({name, ":IRWrite"},  IRWrite,       st == 1 && mr);
      check({name, ":retired"},  instr_retired, adv && last);
      check({name, ":illegal"},  illegal_instr, 1'b0);
      @(posedge clk); #1;
      if (adv) idx++;
      cyc++;
    end
    check({name, ":phases_done"}, idx, seq.size());
  endtask

  initial begin
    logic [6:0]  ops[12];
    logic [31:0] ra, rb;
    int          k;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111, 7'b1110011, 7'b1111111};

    rst_n = 1'b0; OP = '0; funct3 = '0; Zero = 1'b0; LT = 1'b0; LTU = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset:state", state, 4'd0);
    check("reset:outs", all_outs(), 18'd0);

    // Release between edges: RST is held for exactly one more cycle.
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("rst_hold:state", state, 4'd0);
    check("rst_hold:outs", all_outs(), 18'd0);
    @(posedge clk); #1;

    run_instr("add",      7'b0110011, 3'b000, 32'd5, 32'd3, '1);
    run_instr("lw_stall", 7'b0000011, 3'b010, 32'd0, 32'd0, ~32'b11000);
    run_instr("beq_z",    7'b1100011, 3'b000, 32'd7, 32'd7, '1);
    run_instr("bne_z",    7'b1100011, 3'b001, 32'd7, 32'd7, '1);
    run_instr("bltu",     7'b1100011, 3'b110, 32'd1, 32'd2, '1);
    run_instr("blt_neg",  7'b1100011, 3'b100, 32'hFFFF_FFFF, 32'd1, '1);
    run_instr("bf3_010",  7'b1100011, 3'b010, 32'd1, 32'd2, '1);
    run_instr("jal",      7'b1101111, 3'b000, 32'd0, 32'd0, '1);
    run_instr("sw_stall", 7'b0100011, 3'b010, 32'd0, 32'd0, ~32'b11000);
    run_instr("fetch_st", 7'b0010011, 3'b000, 32'd0, 32'd0, ~32'b11);

    // Random instruction mix with sporadic memory stalls.
    for (int i = 0; i < 80; i++) begin
`ifdef ILLEGAL_TRAP_EN
      k = $urandom_range(0, 10);
`else
      k = $urandom_range(0, 11);
`endif
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      run_instr("rand", ops[k], 3'($urandom), ra, rb, $urandom | $urandom);
    end

    // Async reset while a store is stalled in MEMWR.
    mem_ready = 1'b1; OP = 7'b0100011;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("memwr_pre:state", state, 4'd6);
    check("memwr_pre:MemWrite", MemWrite, 1'b1);
    rst_n = 1'b0;
    #1;
    check("memwr_rst:state", state, 4'd0);
    check("memwr_rst:outs", all_outs(), 18'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
    check("after_rst:state", state, 4'd1);

`ifdef ILLEGAL_TRAP_EN
    OP = 7'b1111111;
    @(posedge clk); #1;
    check("trap:decode", state, 4'd2);
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      check("trap:state", state, 4'd15);
      check("trap:flag", illegal_instr, 1'b1);
      check("trap:outs", all_outs(), 18'd1);
      @(posedge clk); #1;
    end
`else
    run_instr("illegal", 7'b1111111, 3'b000, 32'd0, 32'd0, '1);
    check("illegal_back:state", state, 4'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
